// File: rtl/mining_pkg.sv
// ============================================================================
//  Module      : mining_pkg
//  Description : Shared constants and types for the UART mining protocol:
//                header/nonce sizes, byte-index type, dispatcher state enum
//                and a small address range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mining_pkg;

  // Bytes in one block header sent per job, and bytes in the nonce reply.
  localparam int HEADER_BYTES_C = 80;
  localparam int NONCE_BYTES_C  = 4;

  // Width of a header byte index (covers 0..127; only 0..79 are storage).
  localparam int BYTE_IDX_W_C   = 7;

  typedef logic [BYTE_IDX_W_C-1:0] byte_idx_t;

  // Dispatcher control states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_RX_NONCE  = 3'd4,
    ST_FINISH    = 3'd5
  } disp_state_e;

  // True when a byte index addresses a real entry of a buffer of 'depth' bytes.
  function automatic logic idx_in_range(input byte_idx_t idx, input int depth);
    return (int'(idx) < depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/header_buffer.sv
// ============================================================================
//  Module      : header_buffer
//  Description : DEPTH x 8 register file, one synchronous write port and one
//                asynchronous read port. Writes to indices >= DEPTH are
//                dropped; reads from such indices return zero. Contents are
//                never cleared by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module header_buffer
  import mining_pkg::*;
#(
  parameter int DEPTH = HEADER_BYTES_C
) (
  input  logic       clk,
  input  logic       wr_en_i,
  input  byte_idx_t  wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  byte_idx_t  rd_addr_i,
  output logic [7:0] rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = wr_en_i && idx_in_range(wr_addr_i, DEPTH);
  assign w_rd_ok = idx_in_range(rd_addr_i, DEPTH);

  // Store a header byte when the write index lands inside the buffer.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = w_rd_ok ? mem_q[rd_addr_i] : 8'h00;

endmodule

`default_nettype wire

// File: rtl/work_dispatcher.sv
// ============================================================================
//  Module      : work_dispatcher
//  Description : Host-side initiator for the UART mining protocol. Holds one
//                block header, streams it byte 0 first through an external
//                uart_tx, then assembles the little-endian nonce reply
//                delivered by an external uart_rx.
//  Options     : DISPATCH_TIMEOUT_EN - abandon the reply wait after
//                TIMEOUT_CYCLES idle cycles and pulse 'timeout'.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module work_dispatcher
  import mining_pkg::*;
#(
  parameter int          HEADER_BYTES   = HEADER_BYTES_C,
  parameter int          NONCE_BYTES    = NONCE_BYTES_C,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hdr_wr_en,
  input  logic [6:0]  hdr_wr_addr,
  input  logic [7:0]  hdr_wr_data,
  input  logic        go,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [31:0] nonce,
  output logic        done,
  output logic        timeout
);

  localparam byte_idx_t  C_LAST_IDX  = 7'(HEADER_BYTES - 1);
  localparam logic [1:0] C_LAST_RCNT = 2'(NONCE_BYTES - 1);

  disp_state_e state_q;
  byte_idx_t   idx_q;
  logic [1:0]  rcnt_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [31:0] nonce_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  w_hdr_byte;

  // --------------------------------------------------------------------------
  // Header storage: host writes land here at any time; the FSM reads the byte
  // at idx_q at the moment it is issued, so late writes to unsent bytes count.
  // --------------------------------------------------------------------------
  header_buffer #(
    .DEPTH (HEADER_BYTES)
  ) u_header_buffer (
    .clk       (clk),
    .wr_en_i   (hdr_wr_en),
    .wr_addr_i (hdr_wr_addr),
    .wr_data_i (hdr_wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (w_hdr_byte)
  );

  // Nonce shift value with the incoming reply byte placed at its little-endian slot.
  always_comb begin
    shift_d = shift_q;
    shift_d[{rcnt_q, 3'b000} +: 8] = rx_data;
  end

`ifdef DISPATCH_TIMEOUT_EN
  // The pulse is raised on the same edge that the counter reaches its terminal
  // value TIMEOUT_CYCLES-1, so it is compared one count early here.
  localparam logic [31:0] C_TO_PRE = TIMEOUT_CYCLES - 32'd2;

  logic [31:0] cnt_q;
  logic        timeout_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Dispatcher FSM: header issue handshake, reply collection, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rcnt_q     <= '0;
      shift_q    <= '0;
      nonce_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_ISSUE: begin
          // Only hand a byte to the transmitter once it is free.
          if (!tx_busy) begin
            tx_data_q  <= w_hdr_byte;
            tx_start_q <= 1'b1;
            state_q    <= ST_WAIT_BUSY;
          end
        end

        ST_WAIT_BUSY: begin
          // Wait for the transmitter to acknowledge the start strobe.
          if (tx_busy) begin
            state_q <= ST_WAIT_IDLE;
          end
        end

        ST_WAIT_IDLE: begin
          if (!tx_busy) begin
            if (idx_q == C_LAST_IDX) begin
              state_q <= ST_RX_NONCE;
              rcnt_q  <= '0;
              shift_q <= '0;
`ifdef DISPATCH_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              idx_q   <= idx_q + 7'd1;
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_RX_NONCE: begin
          // A received byte always takes priority over the wait limit.
          if (rx_ready) begin
            shift_q <= shift_d;
            rcnt_q  <= rcnt_q + 2'd1;
`ifdef DISPATCH_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (rcnt_q == C_LAST_RCNT) begin
              state_q <= ST_FINISH;
            end
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (cnt_q == C_TO_PRE) begin
            cnt_q     <= cnt_q + 32'd1;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
`endif
        end

        ST_FINISH: begin
          nonce_q <= shift_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign nonce    = nonce_q;
  assign done     = done_q;

`ifdef DISPATCH_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_work_dispatcher.sv
// ============================================================================
//  Module      : tb_work_dispatcher
//  Description : Scoreboard bench for work_dispatcher. Stimulus pushes the
//                expected tx bytes and nonces into queues; a negedge monitor
//                pops and compares whenever tx_start, done or timeout fire.
//                Includes a simple uart_tx busy model (10 clocks per byte).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_work_dispatcher;

  localparam logic [31:0] TB_TIMEOUT_C = 32'd1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        hdr_wr_en;
  logic [6:0]  hdr_wr_addr;
  logic [7:0]  hdr_wr_data;
  logic        go;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] nonce;
  logic        done;
  logic        timeout;

  always #5 clk = ~clk;

  work_dispatcher #(
    .HEADER_BYTES   (80),
    .NONCE_BYTES    (4),
    .TIMEOUT_CYCLES (TB_TIMEOUT_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hdr_wr_en   (hdr_wr_en),
    .hdr_wr_addr (hdr_wr_addr),
    .hdr_wr_data (hdr_wr_data),
    .go          (go),
    .busy        (busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .nonce       (nonce),
    .done        (done),
    .timeout     (timeout)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_nonce[$];
  int          tx_seen = 0;
  int          done_seen = 0;
  int          timeout_seen = 0;
  int          cyc = 0;
  int          last_start = -100;
  logic        prev_start = 1'b0;
  logic        prev_done = 1'b0;
  int          busy_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // uart_tx model: busy for 10 clocks after each start strobe.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    tx_busy = (busy_cnt > 0);
  end

  // Monitor: compare DUT output events against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (reset === 1'b1) begin
      last_start = -100;
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (tx_start === 1'b1) begin
        tx_seen++;
        check("tx_start_width", {31'd0, prev_start}, 32'd0);
        check("tx_spacing_ok", {31'd0, (cyc - last_start) >= 3}, 32'd1);
        check("busy_during_tx", {31'd0, busy}, 32'd1);
        if (exp_tx.size() == 0) begin
          bound_fail("tx_unexpected_byte");
        end else begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        end
        last_start = cyc;
      end
      if (done === 1'b1) begin
        done_seen++;
        check("done_width", {31'd0, prev_done}, 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        if (exp_nonce.size() == 0) begin
          bound_fail("done_unexpected");
        end else begin
          check("nonce", nonce, exp_nonce.pop_front());
        end
      end
      if (timeout === 1'b1) begin
        timeout_seen++;
        check("busy_at_timeout", {31'd0, busy}, 32'd0);
      end
      prev_start = tx_start;
      prev_done  = done;
    end
  end

  task automatic write_hdr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    hdr_wr_en   = 1'b1;
    hdr_wr_addr = a;
    hdr_wr_data = d;
    @(negedge clk);
    hdr_wr_en   = 1'b0;
  endtask

  task automatic push_header(input logic [7:0] last_byte);
    for (int i = 0; i < 79; i++) exp_tx.push_back(8'(i));
    exp_tx.push_back(last_byte);
  endtask

  task automatic start_job();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_tx(input int target);
    int n = 0;
    while (tx_seen < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (tx_seen < target) bound_fail("wait_tx_bytes");
  endtask

  task automatic drain_tx();
    int n = 0;
    repeat (2) @(negedge clk);
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) bound_fail("wait_tx_idle");
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < target) bound_fail("wait_done");
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1; go = 1'b0; hdr_wr_en = 1'b0; hdr_wr_addr = '0; hdr_wr_data = '0;
    rx_data = '0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_nonce", nonce, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) write_hdr(7'(i), 8'(i));

    // Job A: plain header send, reply 78 56 34 12.
    push_header(8'h4F);
    exp_nonce.push_back(32'h1234_5678);
    base = tx_seen;
    start_job();
    wait_tx(base + 80);
    drain_tx();
    rx_byte(8'h78); rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
    wait_done(1);

    // Job B: stray rx byte, second go and out-of-range write during the send.
    push_header(8'h4F);
    exp_nonce.push_back(32'h0000_0001);
    base = tx_seen;
    start_job();
    wait_tx(base + 20);
    rx_byte(8'hAA);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    write_hdr(7'd100, 8'hEE);
    check("nonce_hold", nonce, 32'h1234_5678);
    wait_tx(base + 80);
    drain_tx();
    rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'h00); rx_byte(8'h00);
    wait_done(2);

    // Job C: reset while byte 40 is being issued.
    push_header(8'h4F);
    start_job();
    n = 0;
    while (!(tx_start === 1'b1 && tx_data == 8'd40) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) bound_fail("wait_byte40");
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_nonce", nonce, 32'd0);
    reset = 1'b0;
    exp_tx.delete();

    // Job D: restart from byte 0; rewrite unsent byte 79 mid-job.
    push_header(8'hC3);
    exp_nonce.push_back(32'hDEAD_BEEF);
    base = tx_seen;
    start_job();
    wait_tx(base + 10);
    write_hdr(7'd79, 8'hC3);
    wait_tx(base + 80);
    drain_tx();
    rx_byte(8'hEF); rx_byte(8'hBE); rx_byte(8'hAD); rx_byte(8'hDE);
    wait_done(3);
    write_hdr(7'd79, 8'h4F);

`ifdef DISPATCH_TIMEOUT_EN
    // Job E: only two reply bytes; timeout 1000 cycles after the second.
    push_header(8'h4F);
    base = tx_seen;
    start_job();
    wait_tx(base + 80);
    drain_tx();
    rx_byte(8'h11);
    @(negedge clk);
    rx_data  = 8'h22;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    n = 1;
    while (timeout !== 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'd1000);
    repeat (3) @(negedge clk);
    check("nonce_after_timeout", nonce, 32'hDEAD_BEEF);
    check("busy_after_timeout", {31'd0, busy}, 32'd0);
    check("done_count", 32'(done_seen), 32'd3);
    check("timeout_count", 32'(timeout_seen), 32'd1);
`else
    repeat (20) @(negedge clk);
    check("timeout_count", 32'(timeout_seen), 32'd0);
`endif

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("nonce_queue_empty", 32'(exp_nonce.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/work_dispatcher.md
Name: work_dispatcher

Overview:
- Host-side initiator for the UART mining protocol: holds one 80-byte block header, streams it byte 0 first through a uart_tx instance, then collects the 4-byte nonce reply from a uart_rx instance.
- Reply is little-endian: the first byte received is nonce[7:0].
- Used as the on-chip work feeder in multi-FPGA setups and as the protocol driver in the miner's system-level bench.

Parameters:
- HEADER_BYTES, 80, header length in bytes sent per job.
- NONCE_BYTES, 4, reply length in bytes.
- TIMEOUT_CYCLES, 32'd500_000_000, wait limit for the reply; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- hdr_wr_en  in  1  write strobe into header buffer.
- hdr_wr_addr  in  7  byte index 0..79; writes to 80..127 are ignored.
- hdr_wr_data  in  8  header byte.
- go  in  1  one-cycle pulse that starts a job.
- busy  out  1  high from the cycle after an accepted go until done or timeout.
- tx_data  out  8  byte to uart_tx data_in.
- tx_start  out  1  uart_tx start strobe.
- tx_busy  in  1  uart_tx busy.
- rx_data  in  8  uart_rx data_out.
- rx_ready  in  1  uart_rx one-cycle byte-valid strobe.
- nonce  out  32  assembled nonce; holds its value until the next done.
- done  out  1  one-cycle pulse when the full nonce has been received.
- timeout  out  1  one-cycle pulse on reply timeout; tied 0 without the macro.

Behaviour:
- Reset values: busy=0, tx_start=0, tx_data=0, nonce=0, done=0, timeout=0. State goes to IDLE; byte counter=0. Header buffer contents are NOT cleared.
- Reset mid-job: abandons the job. tx_start drops the next cycle.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, RX_NONCE, FINISH.
- IDLE: go=1 → ISSUE with idx=0. go while busy=1 is ignored.
- ISSUE:
  - If tx_busy=0: drive tx_data=hdr[idx], tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - If tx_busy=1: stay in ISSUE.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_IDLE.
- WAIT_IDLE: wait for tx_busy=0.
  - If idx==HEADER_BYTES-1: go to RX_NONCE with rcnt=0.
  - Otherwise: idx+1, go to ISSUE.
- Byte spacing: at least 3 clocks from one tx_start to the next.
- RX_NONCE: on each rx_ready, shift the byte into nonce_shift[8*rcnt +: 8] and increment rcnt. On the 4th byte, go to FINISH.
- rx_ready outside RX_NONCE: dropped, no side effect.
- FINISH: nonce <= assembled value, done=1 for one cycle, busy=0, go to IDLE.
- Header writes: accepted in any state. A write during a job to an index not yet sent affects the current job (no shadowing).
- idx is 7 bits and rcnt is 2 bits. Neither wraps mid-job, by construction.

Optional Feature:
- Macro DISPATCH_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to RX_NONCE and on every rx_ready, and increments each RX_NONCE cycle.
  - When it reaches TIMEOUT_CYCLES-1: timeout=1 for one cycle, nonce is unchanged, busy=0, state returns to IDLE.
  - rx_ready and the terminal count in the same cycle: the byte wins.
- When not defined: no counter; RX_NONCE waits indefinitely; timeout is constant 0.

Decomposition:
- Package mining_pkg holds:
  - HEADER_BYTES_C=80, NONCE_BYTES_C=4.
  - Dispatcher state enum type.
  - The byte-index typedef (7 bits).
- Sub-module header_buffer: 80x8 single-write / async-read register file with address range check. Reused later by the miner's receive side.

Test Plan:
- Load header bytes 0x00..0x4F, pulse go, uart_tx model holds busy 10 clocks per byte → 80 tx_start pulses carrying 0x00..0x4F in order, each exactly one cycle wide; busy=1 throughout.
- After the header is sent, rx model delivers 0x78,0x56,0x34,0x12 → nonce=0x12345678, done pulses once; busy falls the same cycle.
- Inject rx_ready=1 with data 0xAA during header send, then send the valid reply 0x01,0x00,0x00,0x00 → nonce=0x00000001; the 0xAA byte is ignored.
- go pulsed again mid-job and write to hdr_wr_addr=100 → no restart, buffer unchanged, tx byte sequence identical to the first scenario.
- Assert reset at byte 40 → tx_start=0 next cycle, busy=0. A new go restarts at byte 0x00.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=1000, send only 2 reply bytes → timeout pulses exactly 1000 cycles after the 2nd byte; done never asserts; nonce keeps its prior value.
